spi_cs_arbiter: RTL and testbench

- Shares one SPI master core among 8 requesters (one per chip-select line).
- Round-robin arbitration picks a requester and drives the 3-bit select of the chip-select 1-to-8 demux and the active-low CS level fed into it.
- Sequences each transfer: CS setup delay, SPI start pulse, wait for SPI done, CS hold delay, then an inter-transfer gap.

---
 rtl/spi_cs_arbiter.sv | 168 ++++++++++++++++
 tb/tb_spi_cs_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cs_arbiter.sv
// Round-robin arbiter sharing one SPI master among 8 chip-select requesters.
// Define SPI_ARB_TIMEOUT_EN to add a BUSY-state watchdog driving timeout_err.
module spi_cs_arbiter #(
  parameter int unsigned SETUP_CYC   = 4,
  parameter int unsigned HOLD_CYC    = 4,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic [7:0] req,
  input  logic [7:0] req_mask,
  input  logic       spi_done,
  output logic       spi_start,
  output logic [2:0] cs_sel,
  output logic       cs_n,
  output logic [7:0] grant,
  output logic [7:0] done,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 8;
  localparam int unsigned TW = 11;

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);

  // Elaboration-time range guard on the timing parameters.
  if (SETUP_CYC < 1 || SETUP_CYC > 255 || HOLD_CYC < 1 || HOLD_CYC > 255 ||
      GAP_CYC < 1 || GAP_CYC > 255 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 2047) begin : g_bad_param
    $error("spi_cs_arbiter: timing parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    START = 3'd2,
    BUSY  = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] last;

  logic [N-1:0]  cand_c;
  logic [IW-1:0] idx_c;
  logic [IW-1:0] pick_c;
  logic          pick_vld_c;

  // First enabled request searching upward from the slot after the last grant.
  always_comb begin
    cand_c     = req & req_mask;
    idx_c      = '0;
    pick_c     = '0;
    pick_vld_c = 1'b0;
    for (int i = 1; i <= int'(N); i++) begin
      idx_c = last + IW'(i);
      if (!pick_vld_c && cand_c[idx_c]) begin
        pick_c     = idx_c;
        pick_vld_c = 1'b1;
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tcnt;
`else
  assign timeout_err = 1'b0;
`endif

  // Transfer sequencer; cs_sel only moves on the IDLE->SETUP edge while cs_n is high.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= IW'(N - 1);
      cs_sel    <= '0;
      cs_n      <= 1'b1;
      grant     <= '0;
      done      <= '0;
      spi_start <= 1'b0;
      busy      <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      tcnt        <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      spi_start <= 1'b0;
      done      <= '0;
      unique case (state)
        IDLE: begin
          if (pick_vld_c) begin
            cs_sel <= pick_c;
            grant  <= N'(1) << pick_c;
            last   <= pick_c;
            cs_n   <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt       <= '0;
            spi_start <= 1'b1;
            state     <= START;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        START: begin
`ifdef SPI_ARB_TIMEOUT_EN
          tcnt <= '0;
`endif
          state <= BUSY;
        end
        BUSY: begin
`ifdef SPI_ARB_TIMEOUT_EN
          if (spi_done) begin
            cnt   <= '0;
            state <= HOLD;
          end else if (tcnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            cnt         <= '0;
            state       <= HOLD;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`else
          if (spi_done) begin
            cnt   <= '0;
            state <= HOLD;
          end
`endif
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            cs_n  <= 1'b1;
            done  <= grant;
            grant <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cs_arbiter.sv
// Bench for spi_cs_arbiter: vector table of request/mask patterns with an expected-grant
// scoreboard, plus sequences for spurious done, mid-transfer drop, async reset and watchdog.
module tb_spi_cs_arbiter;

  localparam int SETUP    = 4;
  localparam int HOLD     = 4;
  localparam int GAP      = 2;
  localparam int TMO      = 16;
  localparam int RESP_DLY = 10;
  localparam int BUDGET   = 600;

  logic       clk;
  logic       rstb;
  logic [7:0] req;
  logic [7:0] req_mask;
  logic       resp_done;
  logic       spur_done;
  logic       spi_done;
  logic       spi_start;
  logic [2:0] cs_sel;
  logic       cs_n;
  logic [7:0] grant;
  logic [7:0] done;
  logic       busy;
  logic       timeout_err;
  logic       resp_en;

  assign spi_done = resp_done | spur_done;

  spi_cs_arbiter #(
    .SETUP_CYC  (SETUP),
    .HOLD_CYC   (HOLD),
    .GAP_CYC    (GAP),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .req        (req),
    .req_mask   (req_mask),
    .spi_done   (spi_done),
    .spi_start  (spi_start),
    .cs_sel     (cs_sel),
    .cs_n       (cs_n),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int unsigned exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // SPI master model: answers each start with a done pulse RESP_DLY cycles later.
  initial begin
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rstb && resp_en && spi_start) begin
        repeat (RESP_DLY - 1) @(negedge clk);
        resp_done = 1'b1;
        @(negedge clk);
        resp_done = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pops on each done; checks CS timing and cs_sel stability.
  initial begin : mon
    logic       prev_cs_n;
    logic [2:0] last_sel;
    int         low_cnt, hi_cnt, hold_cnt;
    bit         had_xfer, seen_start, hold_arm;
    prev_cs_n = 1'b1; last_sel = '0; low_cnt = 0; hi_cnt = 0; hold_cnt = 0;
    had_xfer = 0; seen_start = 0; hold_arm = 0;
    forever begin
      @(negedge clk);
      if (!rstb) begin
        prev_cs_n = 1'b1; last_sel = '0; low_cnt = 0; hi_cnt = 0; hold_cnt = 0;
        had_xfer = 0; seen_start = 0; hold_arm = 0;
        continue;
      end
      if (prev_cs_n && !cs_n) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", grant, 0);
        end else begin
          check("cs_sel", cs_sel, exp_q[0]);
          check("grant", grant, 32'd1 << exp_q[0]);
        end
        check("busy_in_xfer", busy, 1);
        if (had_xfer) check("cs_high_gap", (hi_cnt >= GAP + 1) ? GAP + 1 : hi_cnt, GAP + 1);
        low_cnt  = 0;
        last_sel = cs_sel;
      end else begin
        if (cs_sel !== last_sel) check("cs_sel_stable", cs_sel, last_sel);
      end
      if (!prev_cs_n && cs_n) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          check("done", done, 32'd1 << exp_q[0]);
          void'(exp_q.pop_front());
        end
        check("grant_clear", grant, 0);
        if (hold_arm) check("hold_cycles", hold_cnt, HOLD);
        hold_arm = 0;
        had_xfer = 1;
        hi_cnt   = 0;
        done_cnt++;
      end else if (done != 8'h00) begin
        check("done_extra", done, 0);
      end
      if (spi_start) begin
        check("setup_cycles", low_cnt, SETUP);
        check("cs_low_at_start", cs_n, 0);
        seen_start = 1;
      end
      if (!cs_n) begin
        low_cnt++;
        hold_cnt++;
      end else begin
        hi_cnt++;
      end
      if (spi_done && seen_start) begin
        hold_arm   = 1;
        hold_cnt   = 0;
        seen_start = 0;
      end
      prev_cs_n = cs_n;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rstb = 1'b0;
    req = 8'h00;
    req_mask = 8'hFF;
    exp_q.delete();
    @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_cs_sel", cs_sel, 0);
    check("rst_grant", grant, 0);
    check("rst_spi_start", spi_start, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic wait_dones(input int n);
    int target;
    int c;
    target = done_cnt + n;
    c = 0;
    while (done_cnt < target && c < BUDGET) begin
      @(negedge clk);
      c++;
    end
    check("wait_done", done_cnt, target);
  endtask

  task automatic wait_start();
    int c;
    c = 0;
    while (spi_start !== 1'b1 && c < BUDGET) begin
      @(negedge clk);
      c++;
    end
    check("wait_start", spi_start, 1);
  endtask

  task automatic idle_check(input string tag);
    repeat (12) @(negedge clk);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cs_n"}, cs_n, 1);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  typedef struct {
    logic [7:0]  req;
    logic [7:0]  mask;
    int          n;
    logic [31:0] seq;   // expected grant k in nibble k (lowest nibble first)
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  initial begin
    int c;
    rstb = 1'b0; req = 8'h00; req_mask = 8'hFF; spur_done = 1'b0; resp_en = 1'b1;

    vecs[0] = '{req: 8'h04, mask: 8'hFF, n: 1, seq: 32'h0000_0002};
    vecs[1] = '{req: 8'h81, mask: 8'hFF, n: 4, seq: 32'h0000_7070};
    vecs[2] = '{req: 8'hFF, mask: 8'h0A, n: 4, seq: 32'h0000_3131};
    vecs[3] = '{req: 8'hFF, mask: 8'hFF, n: 8, seq: 32'h7654_3210};
    vecs[4] = '{req: 8'h00, mask: 8'hFF, n: 0, seq: 32'h0};
    vecs[5] = '{req: 8'hF0, mask: 8'h0F, n: 0, seq: 32'h0};
    vecs[6] = '{req: 8'h40, mask: 8'hFF, n: 3, seq: 32'h0000_0666};
    vecs[7] = '{req: 8'h24, mask: 8'hFF, n: 3, seq: 32'h0000_0252};
    vecs[8] = '{req: 8'h03, mask: 8'hFF, n: 3, seq: 32'h0000_0010};

    for (int v = 0; v < NV; v++) begin
      do_reset();
      for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(32'(vecs[v].seq[4*k +: 3]));
      req_mask = vecs[v].mask;
      req = vecs[v].req;
      if (vecs[v].n > 0) wait_dones(vecs[v].n);
      else repeat (30) @(negedge clk);
      req = 8'h00;
      idle_check($sformatf("vec%0d", v));
    end

    // spi_done pulses in IDLE and SETUP must be ignored
    do_reset();
    repeat (2) @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (3) @(negedge clk);
    check("spur_idle_busy", busy, 0);
    check("spur_idle_cs_n", cs_n, 1);
    exp_q.push_back(2);
    req = 8'h04;
    c = 0;
    while (cs_n !== 1'b0 && c < BUDGET) begin @(negedge clk); c++; end
    check("spur_grant_seen", cs_n, 0);
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check("spur_setup_cs_n", cs_n, 0);
    wait_dones(1);
    req = 8'h00;
    idle_check("spur");

    // request and mask withdrawn mid-transfer: transfer still completes, no re-grant
    do_reset();
    exp_q.push_back(5);
    req = 8'h20;
    wait_start();
    @(negedge clk);
    req = 8'h00;
    req_mask = 8'h00;
    wait_dones(1);
    req_mask = 8'hFF;
    repeat (20) @(negedge clk);
    idle_check("drop");

    // async reset during HOLD
    do_reset();
    exp_q.push_back(2);
    req = 8'h04;
    c = 0;
    while (spi_done !== 1'b1 && c < BUDGET) begin @(negedge clk); c++; end
    check("arst_spi_done_seen", spi_done, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("arst_pre_cs_n", cs_n, 0);
    rstb = 1'b0;
    #1;
    check("arst_cs_n", cs_n, 1);
    check("arst_grant", grant, 0);
    check("arst_busy", busy, 0);
    exp_q.delete();
    req = 8'h30;
    repeat (2) @(negedge clk);
    exp_q.push_back(4);
    exp_q.push_back(5);
    rstb = 1'b1;
    wait_dones(2);
    req = 8'h00;
    idle_check("arst");

`ifdef SPI_ARB_TIMEOUT_EN
    // watchdog: no spi_done, timeout after TMO BUSY cycles, done still issued
    do_reset();
    resp_en = 1'b0;
    exp_q.push_back(3);
    req = 8'h08;
    wait_start();
    c = 0;
    while (timeout_err !== 1'b1 && c < BUDGET) begin @(negedge clk); c++; end
    check("timeout_latency", c, TMO + 1);
    wait_dones(1);
    req = 8'h00;
    idle_check("tmo");
    check("timeout_sticky", timeout_err, 1);
    resp_en = 1'b1;
    do_reset();
`else
    check("timeout_err_tied", timeout_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

endmodule
